// File: rtl/imem_loader_pkg.sv
// Shared definitions for the instruction-memory loader: state encoding and header width.
package imem_loader_pkg;

  localparam int HDR_W = 16;

  typedef enum logic [2:0] {
    LEN_HI = 3'd0,
    LEN_LO = 3'd1,
    DATA   = 3'd2,
    FLUSH  = 3'd3,
    DONE   = 3'd4,
    ERROR  = 3'd5
  } state_e;

  function automatic logic is_busy(state_e s);
    return s inside {LEN_HI, LEN_LO, DATA, FLUSH};
  endfunction

  function automatic logic takes_bytes(state_e s);
    return s inside {LEN_HI, LEN_LO, DATA};
  endfunction

endpackage

// File: rtl/imem_loader_if.sv
// Byte-stream input channel plus instruction-memory write port of the loader.
interface imem_loader_if #(
  parameter int ADDR_W = 6
) ();

  logic [7:0]        in_data;
  logic              in_valid;
  logic              in_ready;
  logic              imem_we;
  logic [ADDR_W-1:0] imem_addr;
  logic [31:0]       imem_wdata;

  // Host side: supplies bytes and observes the memory write port.
  modport master (
    output in_data, in_valid,
    input  in_ready, imem_we, imem_addr, imem_wdata
  );

  modport slave (
    input  in_data, in_valid,
    output in_ready, imem_we, imem_addr, imem_wdata
  );

endinterface

// File: rtl/imem_loader_byte_word_assembler.sv
// Packs four MSB-first bytes into a 32-bit word and presents it for one cycle.
module byte_word_assembler (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        clr_i,
  input  logic        byte_vld_i,
  input  logic [7:0]  byte_i,
  output logic        last_byte_o,
  output logic        word_valid_o,
  output logic [31:0] word_o
);

  logic [1:0]  cnt_q;
  logic [31:0] shreg_q;
  logic [31:0] shreg_d;
  logic [31:0] word_q;
  logic        word_vld_q;

  assign shreg_d     = {shreg_q[23:0], byte_i};
  assign last_byte_o = byte_vld_i && (cnt_q == 2'd3);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q      <= 2'd0;
      shreg_q    <= '0;
      word_q     <= '0;
      word_vld_q <= 1'b0;
    end else if (clr_i) begin
      cnt_q      <= 2'd0;
      shreg_q    <= '0;
      word_vld_q <= 1'b0;
    end else begin
      word_vld_q <= last_byte_o;
      if (byte_vld_i) begin
        cnt_q   <= cnt_q + 2'd1;
        shreg_q <= shreg_d;
      end
      if (last_byte_o) word_q <= shreg_d;
    end
  end

  assign word_valid_o = word_vld_q;
  assign word_o       = word_q;

endmodule

// File: rtl/imem_loader.sv
// Streams a length-prefixed program into instruction memory, holding the CPU in reset until done.
module imem_loader
  import imem_loader_pkg::*;
#(
  parameter int ADDR_W = 6
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  imem_loader_if.slave      bus,
  output logic              cpu_reset,
  output logic              busy,
  output logic              done,
  output logic              error,
  output logic [ADDR_W:0]   words_loaded
);

  localparam logic [HDR_W-1:0] DEPTH_HDR = HDR_W'(2 ** ADDR_W);
  localparam logic [ADDR_W:0]  ONE       = {{ADDR_W{1'b0}}, 1'b1};

  state_e            state_q, state_d;
  logic [7:0]        len_hi_q;
  logic [ADDR_W:0]   n_q;
  logic [HDR_W-1:0]  hdr;
  logic              in_ready_q, cpu_reset_q, busy_q, done_q, error_q;
  logic [ADDR_W-1:0] addr_q;
  logic [ADDR_W:0]   wl_q;
  logic              accept, arm, asm_byte, last_byte, last_word;
  logic              word_valid;
  logic [31:0]       word;

  assign accept    = bus.in_valid && in_ready_q;
  assign arm       = start && (state_q == DONE || state_q == ERROR);
  assign hdr       = {len_hi_q, bus.in_data};
  assign asm_byte  = accept && (state_q == DATA);
  assign last_word = ((wl_q + ONE) == n_q);

  byte_word_assembler u_asm (
    .clk         (clk),
    .rst_n       (reset),
    .clr_i       (arm),
    .byte_vld_i  (asm_byte),
    .byte_i      (bus.in_data),
    .last_byte_o (last_byte),
    .word_valid_o(word_valid),
    .word_o      (word)
  );

  always_comb begin
    state_d = state_q;
    case (state_q)
      LEN_HI: if (accept) state_d = LEN_LO;
      LEN_LO: if (accept) begin
        if (hdr == '0)             state_d = DONE;
        else if (hdr > DEPTH_HDR)  state_d = ERROR;
        else                       state_d = DATA;
      end
      DATA:   if (last_byte && last_word) state_d = FLUSH;
      FLUSH:  state_d = DONE;
      DONE, ERROR: if (start) state_d = LEN_HI;
      default: state_d = LEN_HI;
    endcase
  end

  // Status outputs are registered from the next state so they line up with state_q.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q     <= LEN_HI;
      in_ready_q  <= 1'b1;
      cpu_reset_q <= 1'b1;
      busy_q      <= 1'b1;
      done_q      <= 1'b0;
      error_q     <= 1'b0;
      len_hi_q    <= '0;
      n_q         <= '0;
      addr_q      <= '0;
      wl_q        <= '0;
    end else begin
      state_q     <= state_d;
      in_ready_q  <= takes_bytes(state_d);
      busy_q      <= is_busy(state_d);
      done_q      <= (state_d == DONE);
      error_q     <= (state_d == ERROR);
      cpu_reset_q <= (state_d != DONE);
      if (accept && state_q == LEN_HI) len_hi_q <= bus.in_data;
      if (accept && state_q == LEN_LO) n_q <= hdr[ADDR_W:0];
      if (arm) begin
        wl_q <= '0;
      end else if (last_byte) begin
        wl_q   <= wl_q + ONE;
        addr_q <= wl_q[ADDR_W-1:0];
      end
    end
  end

  assign bus.in_ready   = in_ready_q;
  assign bus.imem_we    = word_valid;
  assign bus.imem_addr  = addr_q;
  assign bus.imem_wdata = word;
  assign cpu_reset      = cpu_reset_q;
  assign busy           = busy_q;
  assign done           = done_q;
  assign error          = error_q;
  assign words_loaded   = wl_q;

endmodule

// File: tb/tb_imem_loader.sv
// Directed bench for imem_loader: vector tables plus hand-written multi-cycle sequences.
module tb_imem_loader;

  localparam int ADDR_W = 6;
  localparam int DEPTH  = 64;

  logic clk = 1'b0;
  logic reset = 1'b0;
  logic start = 1'b0;
  logic cpu_reset, busy, done, error;
  logic [ADDR_W:0] words_loaded;

  imem_loader_if #(.ADDR_W(ADDR_W)) bus ();

  imem_loader #(.ADDR_W(ADDR_W)) dut (
    .clk         (clk),
    .reset       (reset),
    .start       (start),
    .bus         (bus),
    .cpu_reset   (cpu_reset),
    .busy        (busy),
    .done        (done),
    .error       (error),
    .words_loaded(words_loaded)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;
  int cyc = 0;
  int acc_cyc = 0;

  always @(posedge clk) cyc <= cyc + 1;

  // Memory image and write log captured from the write port
  logic [31:0] mem [DEPTH];
  int          log_addr[$];
  logic [31:0] log_data[$];
  int          log_cyc[$];
  int          log_wl[$];

  always @(negedge clk) begin
    if (bus.imem_we === 1'b1) begin
      mem[bus.imem_addr] = bus.imem_wdata;
      log_addr.push_back(int'(bus.imem_addr));
      log_data.push_back(bus.imem_wdata);
      log_cyc.push_back(cyc);
      log_wl.push_back(int'(words_loaded));
    end
  end

  typedef struct {
    logic [31:0] word;
    int          exp_addr;
    int          exp_wl;
  } wvec_t;

  typedef struct {
    logic [7:0] hi;
    logic [7:0] lo;
    logic       exp_done;
    logic       exp_error;
  } hvec_t;

  wvec_t wv[3];
  hvec_t hv[4];
  int    wcyc[3];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic send_byte(input logic [7:0] b);
    int n = 0;
    @(negedge clk);
    bus.in_data  = b;
    bus.in_valid = 1'b1;
    while (bus.in_ready !== 1'b1 && n < 20) begin
      @(negedge clk);
      n++;
    end
    if (bus.in_ready !== 1'b1) begin
      checks++;
      failures++;
      $display("FAIL send_byte: in_ready got %b expected 1", bus.in_ready);
      bus.in_valid = 1'b0;
      return;
    end
    @(posedge clk);
    #1;
    acc_cyc      = cyc;
    bus.in_valid = 1'b0;
  endtask

  task automatic send_word(input logic [31:0] w);
    send_byte(w[31:24]);
    send_byte(w[23:16]);
    send_byte(w[15:8]);
    send_byte(w[7:0]);
  endtask

  task automatic next_cycle();
    @(negedge clk);
    #1;
  endtask

  task automatic pulse_start();
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    #1;
  endtask

  task automatic clear_log();
    log_addr.delete();
    log_data.delete();
    log_cyc.delete();
    log_wl.delete();
  endtask

  function automatic logic [31:0] pat(input int i);
    logic [7:0] a;
    a = 8'(i);
    return {a, a ^ 8'h5A, 8'hFF - a, 8'hC3};
  endfunction

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int drop;
    int bad;
    logic [31:0] gw [2];

    wv[0] = '{32'h2008000a, 0, 1};
    wv[1] = '{32'h20090005, 1, 2};
    wv[2] = '{32'h01095020, 2, 3};
    hv[0] = '{8'h00, 8'h00, 1'b1, 1'b0};
    hv[1] = '{8'h00, 8'h41, 1'b0, 1'b1};
    hv[2] = '{8'h01, 8'h00, 1'b0, 1'b1};
    hv[3] = '{8'hFF, 8'hFF, 1'b0, 1'b1};
    gw[0] = 32'hdeadbeef;
    gw[1] = 32'h12345678;

    bus.in_data  = 8'h00;
    bus.in_valid = 1'b0;

    #12;
    chk("rst_in_ready", bus.in_ready, 1);
    chk("rst_we", bus.imem_we, 0);
    chk("rst_addr", bus.imem_addr, 0);
    chk("rst_wdata", bus.imem_wdata, 0);
    chk("rst_cpu_reset", cpu_reset, 1);
    chk("rst_busy", busy, 1);
    chk("rst_done", done, 0);
    chk("rst_error", error, 0);
    chk("rst_words", words_loaded, 0);
    @(negedge clk);
    reset = 1'b1;

    // Three-word program, no gaps
    clear_log();
    send_byte(8'h00);
    send_byte(8'h03);
    for (int i = 0; i < 3; i++) begin
      send_word(wv[i].word);
      wcyc[i] = acc_cyc;
    end
    next_cycle();
    chk("t1_flush_we", bus.imem_we, 1);
    chk("t1_flush_busy", busy, 1);
    chk("t1_flush_done", done, 0);
    chk("t1_flush_ready", bus.in_ready, 0);
    next_cycle();
    chk("t1_done", done, 1);
    chk("t1_cpu_reset", cpu_reset, 0);
    chk("t1_busy", busy, 0);
    chk("t1_ready", bus.in_ready, 0);
    chk("t1_words", words_loaded, 3);
    chk("t1_nwrites", log_addr.size(), 3);
    for (int i = 0; i < 3; i++) begin
      if (log_addr.size() > i) begin
        chk("t1_addr", log_addr[i], wv[i].exp_addr);
        chk("t1_data", log_data[i], wv[i].word);
        chk("t1_we_cycle", log_cyc[i], wcyc[i]);
        chk("t1_wl_at_write", log_wl[i], wv[i].exp_wl);
      end
      chk("t1_mem", mem[wv[i].exp_addr], wv[i].word);
    end

    // Header-only streams: empty program and oversize lengths
    pulse_start();
    chk("arm_error", error, 0);
    chk("arm_done", done, 0);
    chk("arm_ready", bus.in_ready, 1);
    chk("arm_cpu_reset", cpu_reset, 1);
    chk("arm_words", words_loaded, 0);
    for (int i = 0; i < 4; i++) begin
      clear_log();
      send_byte(hv[i].hi);
      send_byte(hv[i].lo);
      next_cycle();
      next_cycle();
      chk("hdr_done", done, hv[i].exp_done);
      chk("hdr_error", error, hv[i].exp_error);
      chk("hdr_cpu_reset", cpu_reset, !hv[i].exp_done);
      chk("hdr_ready", bus.in_ready, 0);
      chk("hdr_busy", busy, 0);
      chk("hdr_nwrites", log_addr.size(), 0);
      pulse_start();
      chk("rearm_ready", bus.in_ready, 1);
      chk("rearm_error", error, 0);
      chk("rearm_done", done, 0);
      chk("rearm_busy", busy, 1);
      chk("rearm_cpu_reset", cpu_reset, 1);
    end

    // Two words, one byte every third cycle
    clear_log();
    drop = 0;
    send_byte(8'h00);
    send_byte(8'h02);
    for (int j = 0; j < 8; j++) begin
      send_byte(gw[j / 4][31 - 8 * (j % 4) -: 8]);
      if (j != 7) begin
        repeat (2) begin
          @(negedge clk);
          if (bus.in_ready !== 1'b1) drop++;
        end
      end
    end
    chk("gap_ready_drops", drop, 0);
    next_cycle();
    next_cycle();
    chk("gap_done", done, 1);
    chk("gap_words", words_loaded, 2);
    chk("gap_nwrites", log_addr.size(), 2);
    for (int i = 0; i < 2; i++) begin
      if (log_addr.size() > i) begin
        chk("gap_addr", log_addr[i], i);
        chk("gap_data", log_data[i], gw[i]);
      end
    end

    // Full-depth program
    pulse_start();
    clear_log();
    send_byte(8'h00);
    send_byte(8'h40);
    for (int i = 0; i < DEPTH; i++) send_word(pat(i));
    next_cycle();
    next_cycle();
    chk("full_done", done, 1);
    chk("full_error", error, 0);
    chk("full_words", words_loaded, DEPTH);
    chk("full_nwrites", log_addr.size(), DEPTH);
    bad = 0;
    for (int i = 0; i < log_addr.size(); i++)
      if (log_addr[i] != i || log_data[i] !== pat(i)) bad++;
    chk("full_bad_writes", bad, 0);
    chk("full_last_addr", bus.imem_addr, DEPTH - 1);

    // Reset in the middle of a load
    pulse_start();
    send_byte(8'h00);
    send_byte(8'h02);
    send_word(32'ha1b2c3d4);
    @(negedge clk);
    reset = 1'b0;
    #1;
    chk("mid_rst_ready", bus.in_ready, 1);
    chk("mid_rst_we", bus.imem_we, 0);
    chk("mid_rst_addr", bus.imem_addr, 0);
    chk("mid_rst_wdata", bus.imem_wdata, 0);
    chk("mid_rst_cpu_reset", cpu_reset, 1);
    chk("mid_rst_busy", busy, 1);
    chk("mid_rst_done", done, 0);
    chk("mid_rst_words", words_loaded, 0);
    @(negedge clk);
    reset = 1'b1;
    clear_log();
    send_byte(8'h00);
    send_byte(8'h01);
    send_word(32'hcafef00d);
    next_cycle();
    next_cycle();
    chk("post_rst_done", done, 1);
    chk("post_rst_nwrites", log_addr.size(), 1);
    if (log_addr.size() > 0) begin
      chk("post_rst_addr", log_addr[0], 0);
      chk("post_rst_data", log_data[0], 32'hcafef00d);
    end

    // start held during DATA is ignored
    pulse_start();
    clear_log();
    send_byte(8'h00);
    send_byte(8'h01);
    send_byte(8'h11);
    start = 1'b1;
    send_byte(8'h22);
    start = 1'b0;
    send_byte(8'h33);
    send_byte(8'h44);
    next_cycle();
    next_cycle();
    chk("sd_done", done, 1);
    chk("sd_words", words_loaded, 1);
    chk("sd_nwrites", log_addr.size(), 1);
    chk("sd_mem0", mem[0], 32'h11223344);

    // start in DONE, second program overwrites address 0
    pulse_start();
    chk("reload_cpu_reset", cpu_reset, 1);
    chk("reload_done", done, 0);
    chk("reload_words", words_loaded, 0);
    send_byte(8'h00);
    send_byte(8'h01);
    send_word(32'h55667788);
    next_cycle();
    next_cycle();
    chk("reload_done2", done, 1);
    chk("reload_cpu_reset2", cpu_reset, 0);
    chk("reload_mem0", mem[0], 32'h55667788);
    chk("reload_nwrites", log_addr.size(), 2);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
